// File: rtl/aes_pkg.sv
// AES-128 constants, round-key and column helpers shared by the
// iterative decryptor and its inverse-round datapath.
package aes_pkg;

  localparam int BW = 128;
  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    ROUND,
    DONE
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8];
  // byte (row r, column c) has index 4c + r.
  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_column(
    input logic [31:0] col
  );
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] expand(
    input logic [127:0] rk,
    input logic [7:0]   rcon
  );
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word(rot_word(rk[31:0]))
       ^ {rcon, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one expand step: recover the previous
  // round key from the current one.
  function automatic logic [127:0] inv_expand(
    input logic [127:0] rk,
    input logic [7:0]   rcon
  );
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[31:0] ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96]
       ^ sub_word(rot_word(p3))
       ^ {rcon, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational.
// state_in/rk -> state_out; last skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BW-1:0] state_in,
  input  logic [BW-1:0] rk,
  input  logic          last,
  output logic [BW-1:0] state_out
);

  logic [BW-1:0] sr;
  logic [BW-1:0] sb;
  logic [BW-1:0] ak;

  always_comb begin
    sr = inv_shift_rows(state_in);
    sb = '0;
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = INV_SBOX[sr[127-8*i -: 8]];
    end
    ak = sb ^ rk;
    state_out = ak;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        state_out[127-32*c -: 32] =
          inv_mix_column(ak[127-32*c -: 32]);
      end
    end
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one round per clock.
// in_valid/in_ready take ciphertext+key; out_valid/out_ready return message.
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] ciphertext,
  input  logic [BW-1:0] key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] message
);

  fsm_t fsm_q;
  fsm_t fsm_d;

  logic [3:0]    cnt;
  logic [3:0]    rnd;
  logic [BW-1:0] rk;
  logic [BW-1:0] st;
  logic [BW-1:0] ct_q;
  logic [BW-1:0] key_q;
  logic [BW-1:0] cached_key;
  logic [BW-1:0] cached_rk10;
  logic          cache_vld;

  logic          hit;
  logic          last;
  logic [BW-1:0] rk_next;
  logic [BW-1:0] rk_prev;
  logic [BW-1:0] round_out;

  assign in_ready = (fsm_q == IDLE);
  assign hit      = cache_vld && (key == cached_key);
  assign last     = (rnd == 4'd0);
  assign rk_next  = expand(rk, RCON[cnt]);
  assign rk_prev  = inv_expand(rk, RCON[rnd + 4'd1]);

  aes_inv_round u_round (
    .state_in  (st),
    .rk        (rk_prev),
    .last      (last),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (in_valid) fsm_d = hit ? ROUND : KEYEXP;
      KEYEXP:  if (cnt == NR) fsm_d = ROUND;
      ROUND:   if (last) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rnd         <= '0;
      rk          <= '0;
      st          <= '0;
      ct_q        <= '0;
      key_q       <= '0;
      cached_key  <= '0;
      cached_rk10 <= '0;
      cache_vld   <= 1'b0;
      message     <= '0;
      out_valid   <= 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            ct_q  <= ciphertext;
            key_q <= key;
            if (hit) begin
              // Reuse the last key's final round key.
              rk  <= cached_rk10;
              st  <= ciphertext ^ cached_rk10;
              rnd <= NR - 4'd1;
            end else begin
              rk  <= key;
              cnt <= 4'd1;
            end
          end
        end
        KEYEXP: begin
          rk  <= rk_next;
          cnt <= cnt + 4'd1;
          if (cnt == NR) begin
            st          <= ct_q ^ rk_next;
            cached_key  <= key_q;
            cached_rk10 <= rk_next;
            cache_vld   <= 1'b1;
            rnd         <= NR - 4'd1;
          end
        end
        ROUND: begin
          st <= round_out;
          rk <= rk_prev;
          if (last) begin
            message   <= round_out;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS vectors, cache, back-pressure,
// mid-op reset and random blocks against a software AES encryptor.
module tb_aes_decrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] message;

  int checks;
  int errors;

  logic [7:0]   sb [256];
  bit           mvld;
  logic [127:0] mkey;

  aes_decrypt_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .message    (message)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, v;
    for (int n = 0; n < 256; n++) begin
      v = 8'(n);
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, v);
      sb[n] = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] k,
                                           input logic [127:0] p);
    logic [7:0]   w   [176];
    logic [7:0]   s   [16];
    logic [7:0]   t   [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        a0     = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[a0];
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[4*c+q] = s[4*((c+q)%4)+q];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c];
        a1 = t[4*c+1];
        a2 = t[4*c+2];
        a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c]   = a0;
          s[4*c+1] = a1;
          s[4*c+2] = a2;
          s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
    return (mvld && k == mkey) ? 10 : 20;
  endfunction

  // Drive one block, scramble the inputs while it runs, and report
  // cycles from the accept edge to the edge raising out_valid.
  task automatic send_block(input  logic [127:0] k,
                            input  logic [127:0] c,
                            output int           lat,
                            output logic [127:0] msg,
                            output bit           ok);
    int w;
    ok  = 1'b0;
    lat = 0;
    msg = '0;
    w   = 0;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) return;
    key        = k;
    ciphertext = c;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (lat < 40) begin
      key        = rand128();
      ciphertext = rand128();
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin
        ok  = 1'b1;
        msg = message;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    key        = '0;
    ciphertext = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || message !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b message=%h want 1 0 0",
               in_ready, out_valid, message);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    mvld = 1'b0;
  endtask

  task automatic test_zero_key();
    int lat; logic [127:0] msg; bit ok;
    out_ready = 1'b1;
    send_block('0, Z_CT, lat, msg, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_key: timeout, out_valid never rose");
    end else begin
      if (msg !== '0) begin
        errors++;
        $display("FAIL zero_key msg: got %h want %h", msg, 128'h0);
      end
      checks++;
      if (lat !== 20) begin
        errors++;
        $display("FAIL zero_key latency: got %0d want 20", lat);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_key pulse: out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
    mvld = 1'b1;
    mkey = '0;
  endtask

  task automatic test_fips_c1();
    int lat; logic [127:0] msg; bit ok;
    out_ready = 1'b1;
    send_block(C1_KEY, C1_CT, lat, msg, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL c1: timeout, out_valid never rose");
    end else begin
      if (msg !== C1_PT) begin
        errors++;
        $display("FAIL c1 msg: got %h want %h", msg, C1_PT);
      end
      checks++;
      if (lat !== 20) begin
        errors++;
        $display("FAIL c1 latency: got %0d want 20", lat);
      end
    end
    mvld = 1'b1;
    mkey = C1_KEY;
  endtask

  task automatic test_cache_hit();
    int lat; logic [127:0] msg; bit ok;
    out_ready = 1'b1;
    send_block(C1_KEY, C1_CT, lat, msg, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hit: timeout, out_valid never rose");
    end else begin
      if (msg !== C1_PT) begin
        errors++;
        $display("FAIL hit msg: got %h want %h", msg, C1_PT);
      end
      checks++;
      if (lat !== 10) begin
        errors++;
        $display("FAIL hit latency: got %0d want 10", lat);
      end
    end
    send_block('0, Z_CT, lat, msg, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL miss_after_hit: timeout, out_valid never rose");
    end else begin
      if (msg !== '0) begin
        errors++;
        $display("FAIL miss_after_hit msg: got %h want 0", msg);
      end
      checks++;
      if (lat !== 20) begin
        errors++;
        $display("FAIL miss_after_hit latency: got %0d want 20", lat);
      end
    end
    mvld = 1'b1;
    mkey = '0;
  endtask

  task automatic test_backpressure();
    int lat, el; logic [127:0] msg, kb, pt; bit ok;
    @(posedge clk); #1;
    kb = rand128();
    pt = rand128();
    el = exp_lat(kb);
    out_ready = 1'b0;
    send_block(kb, encrypt(kb, pt), lat, msg, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp: timeout, out_valid never rose");
    end else begin
      if (msg !== pt || lat !== el) begin
        errors++;
        $display("FAIL bp block: msg %h lat %0d want %h lat %0d",
                 msg, lat, pt, el);
      end
    end
    mvld = 1'b1;
    mkey = kb;
    for (int i = 0; i < 7; i++) begin
      in_valid   = 1'b1;
      key        = rand128();
      ciphertext = rand128();
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || message !== pt || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp hold %0d: out_valid=%b in_ready=%b msg=%h want 1 0 %h",
                 i, out_valid, in_ready, message, pt);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || message !== pt) begin
      errors++;
      $display("FAIL bp release: out_valid=%b in_ready=%b msg=%h want 0 1 %h",
               out_valid, in_ready, message, pt);
    end
    pt = rand128();
    send_block(kb, encrypt(kb, pt), lat, msg, ok);
    checks++;
    if (!ok || msg !== pt || lat !== 10) begin
      errors++;
      $display("FAIL bp cache kept: ok=%b msg %h lat %0d want %h lat 10",
               ok, msg, lat, pt);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [127:0] msg; bit ok; bit seen;
    out_ready = 1'b1;
    send_block(C1_KEY, C1_CT, lat, msg, ok);
    checks++;
    if (!ok || msg !== C1_PT || lat !== exp_lat(C1_KEY)) begin
      errors++;
      $display("FAIL rst prep: ok=%b msg %h lat %0d want %h lat %0d",
               ok, msg, lat, C1_PT, exp_lat(C1_KEY));
    end
    mvld = 1'b1;
    mkey = C1_KEY;
    @(posedge clk); #1;
    key        = C1_KEY;
    ciphertext = C1_CT;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || message !== '0) begin
      errors++;
      $display("FAIL rst mid: in_ready=%b out_valid=%b msg=%h want 1 0 0",
               in_ready, out_valid, message);
    end
    rst  = 1'b0;
    mvld = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst aborted: out_valid rose=%b want 0", seen);
    end
    send_block(C1_KEY, C1_CT, lat, msg, ok);
    checks++;
    if (!ok || msg !== C1_PT || lat !== 20) begin
      errors++;
      $display("FAIL rst then c1: ok=%b msg %h lat %0d want %h lat 20",
               ok, msg, lat, C1_PT);
    end
    mvld = 1'b1;
    mkey = C1_KEY;
  endtask

  task automatic test_random();
    logic [127:0] pool [4];
    logic [127:0] k, pt, msg;
    int lat, el, idx; bit ok;
    for (int i = 0; i < 4; i++) pool[i] = rand128();
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      idx = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) pool[idx] = rand128();
      k  = pool[idx];
      pt = rand128();
      el = exp_lat(k);
      send_block(k, encrypt(k, pt), lat, msg, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand %0d: timeout, out_valid never rose", n);
      end else begin
        if (msg !== pt) begin
          errors++;
          $display("FAIL rand %0d msg: got %h want %h", n, msg, pt);
        end
        checks++;
        if (lat !== el) begin
          errors++;
          $display("FAIL rand %0d latency: got %0d want %0d", n, lat, el);
        end
      end
      mvld = 1'b1;
      mkey = k;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    build_sbox();
    test_reset();
    test_zero_key();
    test_fips_c1();
    test_cache_hit();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
